// File: rtl/wshbn_pkg.sv
// Shared types and constants for the Wishbone B4 classic single-access master.
package wshbn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } wshbn_state_t;

    localparam logic [3:0]  WSHBN_SEL_ALL        = 4'hF;
    localparam logic [31:0] WSHBN_ERR_DATA       = 32'h0;
    localparam int          WSHBN_TIMEOUT_CYCLES = 256;

endpackage

// File: rtl/wshbn_master.sv
// Wishbone B4 classic single-access master: turns a held rd/wr request into one CYC/STB cycle.
// Define WSHBN_TIMEOUT_EN to abort cycles that see no ACK/ERR within TIMEOUT_CYCLES.
module wshbn_master
    import wshbn_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = WSHBN_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wshbn_rd,
    input  logic        wshbn_wr,
    input  logic [29:0] wshbn_addr_i,
    input  logic [31:0] wshbn_data_i,
    output logic [31:0] wshbn_data_o,
    output logic        wshbn_busy,
    output logic        wshbn_data_av,
    output logic        wshbn_err,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [29:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("wshbn_master: TIMEOUT_CYCLES must be at least 2");
    end

    wshbn_state_t state, state_next;
    logic         accept;
    logic         finish;
    logic         fail;
    logic         timeout_hit;

`ifdef WSHBN_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TMO_W-1:0] tmo_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (accept) begin
            tmo_cnt <= '0;
        end else if (state == BUS) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign timeout_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ACK/ERR are only meaningful in BUS; ERR beats ACK, and ACK beats the timeout.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        finish     = 1'b0;
        fail       = 1'b0;
        case (state)
            IDLE: begin
                if (wshbn_rd ^ wshbn_wr) begin
                    accept     = 1'b1;
                    state_next = BUS;
                end
            end
            BUS: begin
                if (wb_err_i) begin
                    finish     = 1'b1;
                    fail       = 1'b1;
                    state_next = DONE;
                end else if (wb_ack_i) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end else if (timeout_hit) begin
                    finish     = 1'b1;
                    fail       = 1'b1;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wshbn_data_o  <= '0;
            wshbn_busy    <= 1'b0;
            wshbn_data_av <= 1'b0;
            wshbn_err     <= 1'b0;
            wb_cyc_o      <= 1'b0;
            wb_stb_o      <= 1'b0;
            wb_we_o       <= 1'b0;
            wb_adr_o      <= '0;
            wb_dat_o      <= '0;
            wb_sel_o      <= '0;
        end else begin
            wshbn_data_av <= finish;
            wshbn_err     <= fail;
            if (accept) begin
                wb_adr_o   <= wshbn_addr_i;
                wb_dat_o   <= wshbn_data_i;
                wb_we_o    <= wshbn_wr;
                wb_cyc_o   <= 1'b1;
                wb_stb_o   <= 1'b1;
                wb_sel_o   <= WSHBN_SEL_ALL;
                wshbn_busy <= 1'b1;
            end
            if (finish) begin
                wb_cyc_o   <= 1'b0;
                wb_stb_o   <= 1'b0;
                wb_we_o    <= 1'b0;
                wb_sel_o   <= '0;
                wshbn_busy <= 1'b0;
                // Read data only moves on reads; a failed write leaves it alone.
                if (!wb_we_o) begin
                    wshbn_data_o <= fail ? WSHBN_ERR_DATA : wb_dat_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_wshbn_master.sv
// Directed self-checking bench for wshbn_master with a scoreboard of expected completions.
module tb_wshbn_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        wshbn_rd;
    logic        wshbn_wr;
    logic [29:0] wshbn_addr_i;
    logic [31:0] wshbn_data_i;
    logic [31:0] wshbn_data_o;
    logic        wshbn_busy;
    logic        wshbn_data_av;
    logic        wshbn_err;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [29:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_err_i;

    localparam int TMO = 4;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model_data;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    wshbn_master #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .wshbn_rd     (wshbn_rd),
        .wshbn_wr     (wshbn_wr),
        .wshbn_addr_i (wshbn_addr_i),
        .wshbn_data_i (wshbn_data_i),
        .wshbn_data_o (wshbn_data_o),
        .wshbn_busy   (wshbn_busy),
        .wshbn_data_av(wshbn_data_av),
        .wshbn_err    (wshbn_err),
        .wb_cyc_o     (wb_cyc_o),
        .wb_stb_o     (wb_stb_o),
        .wb_we_o      (wb_we_o),
        .wb_adr_o     (wb_adr_o),
        .wb_dat_o     (wb_dat_o),
        .wb_sel_o     (wb_sel_o),
        .wb_dat_i     (wb_dat_i),
        .wb_ack_i     (wb_ack_i),
        .wb_err_i     (wb_err_i)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    // Completion check: pops the oldest expectation and compares it with what the DUT returned.
    task automatic checkCompletion(input string tag);
        exp_t e;
        checkOutput({tag, " data_av"}, 32'(wshbn_data_av), 32'd1);
        checkOutput({tag, " cyc_drop"}, 32'(wb_cyc_o), 32'd0);
        checkOutput({tag, " busy_drop"}, 32'(wshbn_busy), 32'd0);
        checkOutput({tag, " we_drop"}, 32'(wb_we_o), 32'd0);
        if (sb_q.size() == 0) begin
            checkOutput({tag, " scoreboard_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            checkOutput({tag, " err"}, 32'(wshbn_err), 32'(e.err));
            checkOutput({tag, " data_o"}, wshbn_data_o, e.data);
        end
    endtask

    // Runs one access; the slave answers in the nbus-th BUS cycle with ack and/or err.
    task automatic applyStimulus(input string tag, input logic rd, input logic wr,
                                 input logic [29:0] addr, input logic [31:0] wdata,
                                 input int nbus, input logic ack, input logic err,
                                 input logic [31:0] rdata);
        exp_t e;
        e.err  = err;
        e.data = rd ? (err ? 32'h0 : rdata) : model_data;
        model_data = e.data;
        sb_q.push_back(e);
        wshbn_rd     = rd;
        wshbn_wr     = wr;
        wshbn_addr_i = addr;
        wshbn_data_i = wdata;
        tick();
        for (int i = 1; i <= nbus; i++) begin
            checkOutput({tag, " cyc"}, 32'(wb_cyc_o), 32'd1);
            checkOutput({tag, " stb"}, 32'(wb_stb_o), 32'd1);
            checkOutput({tag, " busy"}, 32'(wshbn_busy), 32'd1);
            checkOutput({tag, " sel"}, 32'(wb_sel_o), 32'hF);
            checkOutput({tag, " we"}, 32'(wb_we_o), 32'(wr));
            checkOutput({tag, " adr"}, 32'(wb_adr_o), 32'(addr));
            if (wr) checkOutput({tag, " dat_o"}, wb_dat_o, wdata);
            checkOutput({tag, " early_av"}, 32'(wshbn_data_av), 32'd0);
            wshbn_addr_i = ~addr;
            wshbn_data_i = ~wdata;
            if (i == nbus) begin
                wb_ack_i = ack;
                wb_err_i = err;
                wb_dat_i = rdata;
            end
            tick();
        end
        checkCompletion(tag);
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_dat_i = 32'hBAD0_BAD0;
        wshbn_rd = 1'b0;
        wshbn_wr = 1'b0;
        tick();
        checkOutput({tag, " av_pulse"}, 32'(wshbn_data_av), 32'd0);
        checkOutput({tag, " err_pulse"}, 32'(wshbn_err), 32'd0);
        checkOutput({tag, " data_hold"}, wshbn_data_o, model_data);
    endtask

    initial begin
        exp_t e;
        int   n;
        logic stayed;
        $display("[TB] start");
        rst          = 1'b1;
        wshbn_rd     = 1'b0;
        wshbn_wr     = 1'b0;
        wshbn_addr_i = '0;
        wshbn_data_i = '0;
        wb_dat_i     = '0;
        wb_ack_i     = 1'b0;
        wb_err_i     = 1'b0;
        model_data   = 32'h0;
        tick();
        tick();
        checkOutput("reset cyc", 32'(wb_cyc_o), 32'd0);
        checkOutput("reset busy", 32'(wshbn_busy), 32'd0);
        checkOutput("reset data_av", 32'(wshbn_data_av), 32'd0);
        checkOutput("reset data_o", wshbn_data_o, 32'h0);
        checkOutput("reset sel", 32'(wb_sel_o), 32'h0);
        rst = 1'b0;
        tick();

        applyStimulus("read1", 1'b1, 1'b0, 30'h0000_0100, 32'h0, 1, 1'b1, 1'b0, 32'hCAFE_0001);
        tick();
        checkOutput("read1 data_hold2", wshbn_data_o, 32'hCAFE_0001);

        applyStimulus("write1", 1'b0, 1'b1, 30'h10, 32'h1234_5678, 5, 1'b1, 1'b0, 32'h5555_AAAA);

        wshbn_rd = 1'b1;
        wshbn_wr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("rdwr_both cyc", 32'(wb_cyc_o), 32'd0);
            checkOutput("rdwr_both busy", 32'(wshbn_busy), 32'd0);
            checkOutput("rdwr_both data_av", 32'(wshbn_data_av), 32'd0);
        end
        wshbn_rd = 1'b0;
        wshbn_wr = 1'b0;
        wb_ack_i = 1'b1;
        wb_err_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checkOutput("idle_ack cyc", 32'(wb_cyc_o), 32'd0);
            checkOutput("idle_ack data_av", 32'(wshbn_data_av), 32'd0);
        end
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        tick();

        applyStimulus("read_err", 1'b1, 1'b0, 30'h20, 32'h0, 2, 1'b0, 1'b1, 32'hDEAD_BEEF);
        applyStimulus("read2", 1'b1, 1'b0, 30'h24, 32'h0, 1, 1'b1, 1'b0, 32'h0BAD_F00D);
        applyStimulus("write_err", 1'b0, 1'b1, 30'h28, 32'hA5A5_5A5A, 3, 1'b0, 1'b1, 32'h7777_7777);
        applyStimulus("ack_and_err", 1'b1, 1'b0, 30'h2C, 32'h0, 1, 1'b1, 1'b1, 32'h1111_2222);
        applyStimulus("read3", 1'b1, 1'b0, 30'h30, 32'h0, 2, 1'b1, 1'b0, 32'h8765_4321);

        wshbn_rd     = 1'b1;
        wshbn_addr_i = 30'h40;
        tick();
        checkOutput("rst_bus cyc_before", 32'(wb_cyc_o), 32'd1);
        rst      = 1'b1;
        wshbn_rd = 1'b0;
        wb_ack_i = 1'b1;
        tick();
        checkOutput("rst_bus cyc", 32'(wb_cyc_o), 32'd0);
        checkOutput("rst_bus stb", 32'(wb_stb_o), 32'd0);
        checkOutput("rst_bus busy", 32'(wshbn_busy), 32'd0);
        checkOutput("rst_bus data_av", 32'(wshbn_data_av), 32'd0);
        rst        = 1'b0;
        wb_ack_i   = 1'b0;
        model_data = 32'h0;
        tick();
        checkOutput("rst_bus idle_av", 32'(wshbn_data_av), 32'd0);
        applyStimulus("after_rst", 1'b1, 1'b0, 30'h44, 32'h0, 1, 1'b1, 1'b0, 32'h4242_4242);

        // No slave response: abort after TMO BUS cycles, or hang on the bus indefinitely.
        wshbn_rd     = 1'b1;
        wshbn_addr_i = 30'h50;
        wb_dat_i     = 32'hFFFF_0000;
`ifdef WSHBN_TIMEOUT_EN
        e.data     = 32'h0;
        e.err      = 1'b1;
        model_data = 32'h0;
        sb_q.push_back(e);
        tick();
        n = 1;
        while (!wshbn_data_av && n < 20) begin
            tick();
            n++;
        end
        checkOutput("timeout cycles", 32'(n), 32'(TMO + 1));
        checkCompletion("timeout");
        wshbn_rd = 1'b0;
        tick();
        checkOutput("timeout av_pulse", 32'(wshbn_data_av), 32'd0);
`else
        tick();
        stayed = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if (!wb_cyc_o || !wb_stb_o || wshbn_data_av) stayed = 1'b0;
            tick();
        end
        checkOutput("no_timeout cyc_held", 32'(stayed), 32'd1);
        n = 0;
        e.data     = 32'h1357_9BDF;
        e.err      = 1'b0;
        model_data = e.data;
        sb_q.push_back(e);
        wb_ack_i = 1'b1;
        wb_dat_i = 32'h1357_9BDF;
        tick();
        checkCompletion("late_ack");
        wb_ack_i = 1'b0;
        wshbn_rd = 1'b0;
        tick();
        checkOutput("late_ack av_pulse", 32'(wshbn_data_av), 32'd0);
`endif
        checkOutput("scoreboard drained", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
